// File: rtl/sdram_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : sdram_addr_gen
// Purpose  : Circular-buffer write/read address generator for the SDRAM
//            logging region, with occupancy and full/empty/overflow/underflow.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_addr_gen #(
    parameter int ROW_BASE  = 0,
    parameter int ROW_LIMIT = 8191
) (
    input  logic        CLK_48MHZ,
    input  logic        RESET,
    input  logic        NEXT_WRITE,
    input  logic        NEXT_READ,
    output logic [1:0]  BA_WRITE,
    output logic [8:0]  COL_WRITE,
    output logic [12:0] ROW_WRITE,
    output logic [1:0]  BA_READ,
    output logic [8:0]  COL_READ,
    output logic [12:0] ROW_READ,
    output logic [23:0] WORD_COUNT,
    output logic        EMPTY,
    output logic        FULL,
    output logic        OVERFLOW,
    output logic        UNDERFLOW
);

    localparam logic [12:0] ROW_BASE_C  = 13'(ROW_BASE);
    localparam logic [12:0] ROW_LIMIT_C = 13'(ROW_LIMIT);
    localparam logic [24:0] CAPACITY    = 25'(4 * (ROW_LIMIT - ROW_BASE + 1) * 512);

    typedef struct packed {
        logic [1:0]  ba;
        logic [12:0] row;
        logic [8:0]  col;
    } ptr_t;

    localparam ptr_t PTR_RESET = '{ba: 2'd0, row: ROW_BASE_C, col: 9'd0};

    logic        wr_sync, wr_prev, rd_sync, rd_prev;
    logic        wr_ev, rd_ev;
    logic        is_empty, is_full;
    ptr_t        wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic [24:0] count, count_n;
    logic        ovf_n, unf_n;

    // Column, then row within the region, then bank; full wrap after bank 3.
    function automatic ptr_t next_ptr(input ptr_t p);
        ptr_t n;
        n = p;
        if (p.col == 9'd511) begin
            n.col = 9'd0;
            if (p.row == ROW_LIMIT_C) begin
                n.row = ROW_BASE_C;
                n.ba  = p.ba + 2'd1;
            end else begin
                n.row = p.row + 13'd1;
            end
        end else begin
            n.col = p.col + 9'd1;
        end
        return n;
    endfunction

    assign wr_ev    = wr_sync & ~wr_prev;
    assign rd_ev    = rd_sync & ~rd_prev;
    assign is_empty = (count == 25'd0);
    assign is_full  = (count == CAPACITY);

    always_comb begin
        wr_ptr_n = wr_ptr;
        rd_ptr_n = rd_ptr;
        count_n  = count;
        ovf_n    = OVERFLOW;
        unf_n    = UNDERFLOW;
        if (wr_ev && rd_ev) begin
            wr_ptr_n = next_ptr(wr_ptr);
            if (is_empty) begin
                count_n = count + 25'd1;
                unf_n   = 1'b1;
            end else begin
                rd_ptr_n = next_ptr(rd_ptr);
            end
        end else if (wr_ev) begin
            wr_ptr_n = next_ptr(wr_ptr);
            if (is_full) begin
                // Oldest word is sacrificed so the newest sample is kept.
                rd_ptr_n = next_ptr(rd_ptr);
                ovf_n    = 1'b1;
            end else begin
                count_n = count + 25'd1;
            end
        end else if (rd_ev) begin
            if (is_empty) begin
                unf_n = 1'b1;
            end else begin
                rd_ptr_n = next_ptr(rd_ptr);
                count_n  = count - 25'd1;
            end
        end
    end

    always_ff @(posedge CLK_48MHZ) begin
        if (RESET) begin
            wr_sync    <= 1'b0;
            wr_prev    <= 1'b0;
            rd_sync    <= 1'b0;
            rd_prev    <= 1'b0;
            wr_ptr     <= PTR_RESET;
            rd_ptr     <= PTR_RESET;
            count      <= 25'd0;
            WORD_COUNT <= 24'd0;
            EMPTY      <= 1'b1;
            FULL       <= 1'b0;
            OVERFLOW   <= 1'b0;
            UNDERFLOW  <= 1'b0;
        end else begin
            wr_sync    <= NEXT_WRITE;
            wr_prev    <= wr_sync;
            rd_sync    <= NEXT_READ;
            rd_prev    <= rd_sync;
            wr_ptr     <= wr_ptr_n;
            rd_ptr     <= rd_ptr_n;
            count      <= count_n;
            // A full 2^24-word region cannot be shown in 24 bits; saturate.
            WORD_COUNT <= count_n[24] ? 24'hFFFFFF : count_n[23:0];
            EMPTY      <= (count_n == 25'd0);
            FULL       <= (count_n == CAPACITY);
            OVERFLOW   <= ovf_n;
            UNDERFLOW  <= unf_n;
        end
    end

    assign BA_WRITE  = wr_ptr.ba;
    assign ROW_WRITE = wr_ptr.row;
    assign COL_WRITE = wr_ptr.col;
    assign BA_READ   = rd_ptr.ba;
    assign ROW_READ  = rd_ptr.row;
    assign COL_READ  = rd_ptr.col;

endmodule
`default_nettype wire

// File: tb/tb_sdram_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_addr_gen
// Purpose  : Directed self-checking bench for sdram_addr_gen (2-row region).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_addr_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        next_write = 1'b0;
    logic        next_read  = 1'b0;
    logic [1:0]  ba_write, ba_read;
    logic [8:0]  col_write, col_read;
    logic [12:0] row_write, row_read;
    logic [23:0] word_count;
    logic        empty, full, overflow, underflow;

    int n_checks = 0;
    int n_fail   = 0;

    sdram_addr_gen #(.ROW_BASE(0), .ROW_LIMIT(1)) dut (
        .CLK_48MHZ  (clk),
        .RESET      (rst),
        .NEXT_WRITE (next_write),
        .NEXT_READ  (next_read),
        .BA_WRITE   (ba_write),
        .COL_WRITE  (col_write),
        .ROW_WRITE  (row_write),
        .BA_READ    (ba_read),
        .COL_READ   (col_read),
        .ROW_READ   (row_read),
        .WORD_COUNT (word_count),
        .EMPTY      (empty),
        .FULL       (full),
        .OVERFLOW   (overflow),
        .UNDERFLOW  (underflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        idle(n);
        rst = 1'b0;
        idle(2);
    endtask

    // One-cycle high, one-cycle low; outputs are settled on return.
    task automatic pulse(input logic wr, input logic rd, input int n);
        for (int i = 0; i < n; i++) begin
            next_write = wr;
            next_read  = rd;
            @(negedge clk);
            next_write = 1'b0;
            next_read  = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ba_w"},  32'(ba_write),   32'd0);
        check_eq({tag, "_row_w"}, 32'(row_write),  32'd0);
        check_eq({tag, "_col_w"}, 32'(col_write),  32'd0);
        check_eq({tag, "_ba_r"},  32'(ba_read),    32'd0);
        check_eq({tag, "_row_r"}, 32'(row_read),   32'd0);
        check_eq({tag, "_col_r"}, 32'(col_read),   32'd0);
        check_eq({tag, "_count"}, 32'(word_count), 32'd0);
        check_eq({tag, "_empty"}, 32'(empty),      32'd1);
        check_eq({tag, "_full"},  32'(full),       32'd0);
        check_eq({tag, "_ovf"},   32'(overflow),   32'd0);
        check_eq({tag, "_unf"},   32'(underflow),  32'd0);
    endtask

    initial begin
        do_reset(3);
        check_all_zero("reset");

        pulse(1'b1, 1'b0, 512);
        check_eq("w512_ba",    32'(ba_write),   32'd0);
        check_eq("w512_row",   32'(row_write),  32'd1);
        check_eq("w512_col",   32'(col_write),  32'd0);
        check_eq("w512_count", 32'(word_count), 32'd512);
        check_eq("w512_row_r", 32'(row_read),   32'd0);
        check_eq("w512_col_r", 32'(col_read),   32'd0);
        check_eq("w512_empty", 32'(empty),      32'd0);

        pulse(1'b1, 1'b0, 512);
        check_eq("w1024_ba",  32'(ba_write),  32'd1);
        check_eq("w1024_row", 32'(row_write), 32'd0);
        check_eq("w1024_col", 32'(col_write), 32'd0);

        pulse(1'b1, 1'b0, 3071);
        check_eq("w4095_full", 32'(full), 32'd0);
        pulse(1'b1, 1'b0, 1);
        check_eq("fill_full",  32'(full),       32'd1);
        check_eq("fill_count", 32'(word_count), 32'd4096);
        check_eq("fill_ba",    32'(ba_write),   32'd0);
        check_eq("fill_row",   32'(row_write),  32'd0);
        check_eq("fill_col",   32'(col_write),  32'd0);
        check_eq("fill_ovf",   32'(overflow),   32'd0);

        pulse(1'b1, 1'b0, 1);
        check_eq("ovf_flag",  32'(overflow),   32'd1);
        check_eq("ovf_col_r", 32'(col_read),   32'd1);
        check_eq("ovf_col_w", 32'(col_write),  32'd1);
        check_eq("ovf_count", 32'(word_count), 32'd4096);
        check_eq("ovf_full",  32'(full),       32'd1);

        do_reset(2);
        check_all_zero("reset2");
        pulse(1'b0, 1'b1, 1);
        check_eq("unf_flag",  32'(underflow),  32'd1);
        check_eq("unf_col_r", 32'(col_read),   32'd0);
        check_eq("unf_row_r", 32'(row_read),   32'd0);
        check_eq("unf_count", 32'(word_count), 32'd0);
        check_eq("unf_empty", 32'(empty),      32'd1);

        do_reset(2);
        pulse(1'b1, 1'b0, 5);
        check_eq("pre_both_count", 32'(word_count), 32'd5);
        pulse(1'b1, 1'b1, 1);
        check_eq("both_col_w", 32'(col_write),  32'd6);
        check_eq("both_col_r", 32'(col_read),   32'd1);
        check_eq("both_count", 32'(word_count), 32'd5);
        check_eq("both_ovf",   32'(overflow),   32'd0);
        check_eq("both_unf",   32'(underflow),  32'd0);

        do_reset(2);
        next_write = 1'b1;
        idle(10);
        next_write = 1'b0;
        idle(3);
        check_eq("hold_col_w", 32'(col_write),  32'd1);
        check_eq("hold_count", 32'(word_count), 32'd1);

        // Reset coincides with a rising write edge; the event must vanish.
        @(negedge clk);
        rst        = 1'b1;
        next_write = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        next_write = 1'b0;
        idle(3);
        check_all_zero("rst_ev");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
